// File: rtl/sdram_burst_master_if.sv
// Signal bundle between the burst master, the user FIFOs and the SDRAM controller user ports.
// master: the burst requester; slave: the FIFO/controller side.
interface sdram_burst_master_if;
  logic        sdram_init_done;
  logic [20:0] wr_min_addr;
  logic [20:0] wr_max_addr;
  logic [20:0] rd_min_addr;
  logic [20:0] rd_max_addr;
  logic [9:0]  wr_len;
  logic [9:0]  rd_len;
  logic        wr_load;
  logic        rd_load;
  logic        rd_en;
  logic [10:0] wr_fifo_level;
  logic [15:0] wr_fifo_q;
  logic        wr_fifo_rdreq;
  logic [10:0] rd_fifo_level;
  logic        rd_fifo_wrreq;
  logic [15:0] rd_fifo_data;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic [20:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic [15:0] sdram_din;
  logic        sdram_rd_req;
  logic        sdram_rd_ack;
  logic [20:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;
  logic [15:0] sdram_dout;
  logic        burst_err;

  modport master (
    input  sdram_init_done, wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr,
           wr_len, rd_len, wr_load, rd_load, rd_en, wr_fifo_level, wr_fifo_q,
           rd_fifo_level, sdram_wr_ack, sdram_rd_ack, sdram_dout,
    output wr_fifo_rdreq, rd_fifo_wrreq, rd_fifo_data, sdram_wr_req, sdram_wr_addr,
           sdram_wr_burst, sdram_din, sdram_rd_req, sdram_rd_addr, sdram_rd_burst, burst_err
  );

  modport slave (
    output sdram_init_done, wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr,
           wr_len, rd_len, wr_load, rd_load, rd_en, wr_fifo_level, wr_fifo_q,
           rd_fifo_level, sdram_wr_ack, sdram_rd_ack, sdram_dout,
    input  wr_fifo_rdreq, rd_fifo_wrreq, rd_fifo_data, sdram_wr_req, sdram_wr_addr,
           sdram_wr_burst, sdram_din, sdram_rd_req, sdram_rd_addr, sdram_rd_burst, burst_err
  );
endinterface

// File: rtl/sdram_burst_master.sv
// Whole-burst write/read requester for the SDRAM controller user ports, with circular
// address regions and round-robin arbitration between the two channels.
//
// state   | meaning
// IDLE    | waiting for an eligible channel; loads rewind addresses here
// WR_REQ  | write request raised, waiting for first ack
// WR_DATA | write words popped from FIFO while ack is high
// RD_REQ  | read request raised, waiting for first ack
// RD_DATA | read words pushed into FIFO while ack is high
module sdram_burst_master #(
  parameter int RD_FIFO_DEPTH = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  sdram_burst_master_if.master sdram_io
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA} state_e;

  localparam logic [11:0] RdDepth = 12'(RD_FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [20:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic        last_wr_q, last_wr_d;
  logic [10:0] cnt_q, cnt_d;
  logic        ack_prev_q, ack_prev_d;
  logic [20:0] lat_min_q, lat_min_d, lat_max_q, lat_max_d;
  logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [20:0] wr_out_addr_q, wr_out_addr_d, rd_out_addr_q, rd_out_addr_d;
  logic [9:0]  wr_burst_q, wr_burst_d, rd_burst_q, rd_burst_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_push_q, rd_push_d;
  logic        err_q, err_d;

  logic        wr_ok, rd_ok, in_wr, in_rd, ch_ack, burst_end, wrap;
  logic [11:0] rd_sum;
  logic [9:0]  cur_len;
  logic [20:0] cur_base, wr_cur, rd_cur, adv_addr;
  logic [21:0] next_addr, next_end;

  assign rd_sum = {1'b0, sdram_io.rd_fifo_level} + {2'b0, sdram_io.rd_len};
  assign wr_ok  = (sdram_io.wr_len != 10'd0) && (sdram_io.wr_fifo_level >= {1'b0, sdram_io.wr_len});
  assign rd_ok  = sdram_io.rd_en && (sdram_io.rd_len != 10'd0) && (rd_sum <= RdDepth);

  assign in_wr     = (state_q == WR_REQ) || (state_q == WR_DATA);
  assign in_rd     = (state_q == RD_REQ) || (state_q == RD_DATA);
  assign ch_ack    = in_wr ? sdram_io.sdram_wr_ack : sdram_io.sdram_rd_ack;
  assign burst_end = ack_prev_q && !ch_ack && ((state_q == WR_DATA) || (state_q == RD_DATA));

  // Advance uses the values latched at request entry; 22-bit compare avoids wrapping past 2^21.
  assign cur_len   = in_wr ? wr_burst_q : rd_burst_q;
  assign cur_base  = in_wr ? wr_out_addr_q : rd_out_addr_q;
  assign next_addr = {1'b0, cur_base} + {12'd0, cur_len};
  assign next_end  = next_addr + {12'd0, cur_len};
  assign wrap      = (next_end > {1'b0, lat_max_q}) || (next_addr >= {1'b0, lat_max_q});
  assign adv_addr  = wrap ? lat_min_q : next_addr[20:0];

  assign wr_cur = (sdram_io.wr_load || wr_pend_q) ? sdram_io.wr_min_addr : wr_addr_q;
  assign rd_cur = (sdram_io.rd_load || rd_pend_q) ? sdram_io.rd_min_addr : rd_addr_q;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_pend_d     = wr_pend_q | sdram_io.wr_load;
    rd_pend_d     = rd_pend_q | sdram_io.rd_load;
    last_wr_d     = last_wr_q;
    cnt_d         = cnt_q;
    ack_prev_d    = (in_wr || in_rd) && ch_ack;
    lat_min_d     = lat_min_q;
    lat_max_d     = lat_max_q;
    wr_req_d      = wr_req_q;
    rd_req_d      = rd_req_q;
    wr_out_addr_d = wr_out_addr_q;
    rd_out_addr_d = rd_out_addr_q;
    wr_burst_d    = wr_burst_q;
    rd_burst_d    = rd_burst_q;
    rd_data_d     = rd_data_q;
    rd_push_d     = 1'b0;
    err_d         = err_q;

    if ((in_wr || in_rd) && ch_ack) cnt_d = cnt_q + 11'd1;
    if (in_rd && sdram_io.sdram_rd_ack) begin
      rd_push_d = 1'b1;
      rd_data_d = sdram_io.sdram_dout;
    end

    case (state_q)
      IDLE: begin
        wr_addr_d = wr_cur;
        rd_addr_d = rd_cur;
        wr_pend_d = 1'b0;
        rd_pend_d = 1'b0;
        if (sdram_io.sdram_init_done && wr_ok && (!rd_ok || !last_wr_q)) begin
          state_d       = WR_REQ;
          wr_req_d      = 1'b1;
          wr_out_addr_d = wr_cur;
          wr_burst_d    = sdram_io.wr_len;
          lat_min_d     = sdram_io.wr_min_addr;
          lat_max_d     = sdram_io.wr_max_addr;
          cnt_d         = 11'd0;
        end else if (sdram_io.sdram_init_done && rd_ok) begin
          state_d       = RD_REQ;
          rd_req_d      = 1'b1;
          rd_out_addr_d = rd_cur;
          rd_burst_d    = sdram_io.rd_len;
          lat_min_d     = sdram_io.rd_min_addr;
          lat_max_d     = sdram_io.rd_max_addr;
          cnt_d         = 11'd0;
        end
      end
      WR_REQ: begin
        if (sdram_io.sdram_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = WR_DATA;
        end
      end
      RD_REQ: begin
        if (sdram_io.sdram_rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = RD_DATA;
        end
      end
      WR_DATA, RD_DATA: begin
        if (burst_end) begin
          err_d     = err_q | (cnt_q != {1'b0, cur_len});
          last_wr_d = !last_wr_q;
          state_d   = IDLE;
          // A load seen during the burst overrides the normal advance.
          if (in_wr) begin
            wr_addr_d = (wr_pend_q || sdram_io.wr_load) ? lat_min_q : adv_addr;
            wr_pend_d = 1'b0;
          end else begin
            rd_addr_d = (rd_pend_q || sdram_io.rd_load) ? lat_min_q : adv_addr;
            rd_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_pend_q     <= 1'b1;
      rd_pend_q     <= 1'b1;
      last_wr_q     <= 1'b0;
      cnt_q         <= '0;
      ack_prev_q    <= 1'b0;
      lat_min_q     <= '0;
      lat_max_q     <= '0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      wr_out_addr_q <= '0;
      rd_out_addr_q <= '0;
      wr_burst_q    <= '0;
      rd_burst_q    <= '0;
      rd_data_q     <= '0;
      rd_push_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
      last_wr_q     <= last_wr_d;
      cnt_q         <= cnt_d;
      ack_prev_q    <= ack_prev_d;
      lat_min_q     <= lat_min_d;
      lat_max_q     <= lat_max_d;
      wr_req_q      <= wr_req_d;
      rd_req_q      <= rd_req_d;
      wr_out_addr_q <= wr_out_addr_d;
      rd_out_addr_q <= rd_out_addr_d;
      wr_burst_q    <= wr_burst_d;
      rd_burst_q    <= rd_burst_d;
      rd_data_q     <= rd_data_d;
      rd_push_q     <= rd_push_d;
      err_q         <= err_d;
    end
  end

  assign sdram_io.sdram_wr_req   = wr_req_q;
  assign sdram_io.sdram_rd_req   = rd_req_q;
  assign sdram_io.sdram_wr_addr  = wr_out_addr_q;
  assign sdram_io.sdram_wr_burst = wr_burst_q;
  assign sdram_io.sdram_rd_addr  = rd_out_addr_q;
  assign sdram_io.sdram_rd_burst = rd_burst_q;
  assign sdram_io.sdram_din      = sdram_io.wr_fifo_q;
  // Pop is held off while reset is asserted so a mid-burst reset leaves the FIFO alone.
  assign sdram_io.wr_fifo_rdreq  = rst_n && in_wr && sdram_io.sdram_wr_ack;
  assign sdram_io.rd_fifo_wrreq  = rd_push_q;
  assign sdram_io.rd_fifo_data   = rd_data_q;
  assign sdram_io.burst_err      = err_q;

endmodule

// File: tb/tb_sdram_burst_master.sv
// Bench for sdram_burst_master: directed scenarios plus randomized regions, checked against
// an arithmetic model of addresses, arbitration, data paths and the sticky error flag.
module tb_sdram_burst_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_burst_master_if bus ();

  sdram_burst_master #(.RD_FIFO_DEPTH(1024)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sdram_io (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_min, wr_max, wr_len, rd_min, rd_max, rd_len, wr_lvl, rd_lvl;
  bit rd_en_m;
  int exp_wr_a, exp_rd_a, last_end;
  bit wr_pend_m, rd_pend_m, last_wr_m, err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int adv(input int a, input int len, input int mn, input int mx);
    int n;
    n = a + len;
    if ((n + len > mx) || (n >= mx)) return mn;
    return n;
  endfunction

  task automatic apply_cfg();
    bus.wr_min_addr   = wr_min[20:0];
    bus.wr_max_addr   = wr_max[20:0];
    bus.rd_min_addr   = rd_min[20:0];
    bus.rd_max_addr   = rd_max[20:0];
    bus.wr_len        = wr_len[9:0];
    bus.rd_len        = rd_len[9:0];
    bus.wr_fifo_level = wr_lvl[10:0];
    bus.rd_fifo_level = rd_lvl[10:0];
    bus.rd_en         = rd_en_m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    bus.wr_load = 1'b0;
    bus.rd_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr_a = 0; exp_rd_a = 0;
    wr_pend_m = 1'b1; rd_pend_m = 1'b1;
    last_wr_m = 1'b0; err_m = 1'b0;
    last_end = -100;
  endtask

  task automatic wait_req(output bit got_wr, output int at);
    int k;
    got_wr = 1'b0;
    at = cyc;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (bus.sdram_wr_req || bus.sdram_rd_req) break;
    end
    check("req_timeout", k < 300, 1);
    check("req_overlap", bus.sdram_wr_req && bus.sdram_rd_req, 0);
    got_wr = bus.sdram_wr_req;
    at = cyc;
  endtask

  // Controller model: optional wait, then nack consecutive ack cycles, then ack low.
  task automatic run_burst(input bit is_wr, input int nack, input int load_at);
    int exp_a, lmin, lmax, llen, d, pops;
    bit loaded;
    logic [15:0] prev, val;
    if (is_wr) begin
      exp_a = wr_pend_m ? wr_min : exp_wr_a;
      lmin = wr_min; lmax = wr_max; llen = wr_len;
      check("wr_addr", bus.sdram_wr_addr, exp_a);
      check("wr_burst", bus.sdram_wr_burst, llen);
    end else begin
      exp_a = rd_pend_m ? rd_min : exp_rd_a;
      lmin = rd_min; lmax = rd_max; llen = rd_len;
      check("rd_addr", bus.sdram_rd_addr, exp_a);
      check("rd_burst", bus.sdram_rd_burst, llen);
    end
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk); #1;
      check("req_hold", is_wr ? bus.sdram_wr_req : bus.sdram_rd_req, 1);
    end
    pops = 0; loaded = 1'b0; prev = '0;
    for (int i = 0; i < nack; i++) begin
      @(negedge clk);
      val = 16'($urandom);
      if (is_wr) begin
        bus.sdram_wr_ack = 1'b1;
        bus.wr_fifo_q = val;
      end else begin
        bus.sdram_rd_ack = 1'b1;
        bus.sdram_dout = val;
      end
      if (i == load_at) begin
        if (is_wr) bus.wr_load = 1'b1; else bus.rd_load = 1'b1;
        loaded = 1'b1;
      end else begin
        bus.wr_load = 1'b0;
        bus.rd_load = 1'b0;
      end
      #1;
      if (i == 1) check("req_drop", is_wr ? bus.sdram_wr_req : bus.sdram_rd_req, 0);
      if (is_wr) begin
        if (bus.wr_fifo_rdreq === 1'b1) pops++;
        check("wr_din", bus.sdram_din, val);
      end else begin
        check("rd_push", bus.rd_fifo_wrreq, i > 0);
        if (i > 0) check("rd_data", bus.rd_fifo_data, prev);
      end
      prev = val;
    end
    @(negedge clk);
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    bus.wr_load = 1'b0;
    bus.rd_load = 1'b0;
    #1;
    if (is_wr) begin
      check("wr_pops", pops, nack);
      check("wr_pop_off", bus.wr_fifo_rdreq, 0);
    end else begin
      check("rd_push_last", bus.rd_fifo_wrreq, 1);
      check("rd_data_last", bus.rd_fifo_data, prev);
    end
    last_end = cyc;
    @(negedge clk); #1;
    if (!is_wr) check("rd_push_off", bus.rd_fifo_wrreq, 0);
    check("req_idle", bus.sdram_wr_req | bus.sdram_rd_req, 0);
    if (is_wr) begin
      exp_wr_a = loaded ? lmin : adv(exp_a, llen, lmin, lmax);
      wr_pend_m = 1'b0;
    end else begin
      exp_rd_a = loaded ? lmin : adv(exp_a, llen, lmin, lmax);
      rd_pend_m = 1'b0;
    end
    last_wr_m = !last_wr_m;
    if (nack != llen) err_m = 1'b1;
    check("burst_err", bus.burst_err, err_m);
  endtask

  task automatic next_burst(input int nack, input int load_at);
    bit wok, rok, exp_wr, got_wr;
    int at;
    wok = (wr_len != 0) && (wr_lvl >= wr_len);
    rok = rd_en_m && (rd_len != 0) && (rd_lvl + rd_len <= 1024);
    exp_wr = wok && (!rok || !last_wr_m);
    wait_req(got_wr, at);
    check("arb_chan", got_wr, exp_wr);
    check("gap_min2", (at - last_end) >= 2, 1);
    run_burst(got_wr, nack, load_at);
  endtask

  initial begin
    int hits;
    bit gw;
    int at;
    bus.sdram_init_done = 1'b1;
    bus.wr_fifo_q = '0;
    bus.sdram_dout = '0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    bus.wr_load = 1'b0;
    bus.rd_load = 1'b0;
    wr_min = 0; wr_max = 1024; wr_len = 0; wr_lvl = 0;
    rd_min = 0; rd_max = 1024; rd_len = 0; rd_lvl = 0; rd_en_m = 1'b0;
    apply_cfg();

    // Reset values
    do_reset();
    @(negedge clk); #1;
    check("rst_wr_req", bus.sdram_wr_req, 0);
    check("rst_rd_req", bus.sdram_rd_req, 0);
    check("rst_wr_addr", bus.sdram_wr_addr, 0);
    check("rst_wr_burst", bus.sdram_wr_burst, 0);
    check("rst_rd_addr", bus.sdram_rd_addr, 0);
    check("rst_rd_burst", bus.sdram_rd_burst, 0);
    check("rst_rd_data", bus.rd_fifo_data, 0);
    check("rst_rd_push", bus.rd_fifo_wrreq, 0);
    check("rst_wr_pop", bus.wr_fifo_rdreq, 0);
    check("rst_err", bus.burst_err, 0);

    // Write wrap: 0,256,512,768,0
    wr_min = 0; wr_max = 1024; wr_len = 256; wr_lvl = 1000;
    apply_cfg();
    do_reset();
    repeat (5) next_burst(256, -1);

    // Tie arbitration W,R,W,R
    wr_len = 8; rd_len = 8; rd_en_m = 1'b1; rd_lvl = 0;
    apply_cfg();
    do_reset();
    repeat (4) next_burst(8, -1);

    // Read backpressure
    wr_len = 0; rd_len = 64; rd_lvl = 961; rd_en_m = 1'b1;
    apply_cfg();
    do_reset();
    hits = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.sdram_rd_req !== 1'b0) hits++;
    end
    check("bp_no_req", hits, 0);
    @(negedge clk);
    rd_lvl = 960; apply_cfg();
    @(negedge clk); #1;
    check("bp_req_rise", bus.sdram_rd_req, 1);
    run_burst(1'b0, 64, -1);

    // Init gating, then rd_load mid-burst
    wr_len = 8; wr_lvl = 1000; rd_len = 0; rd_en_m = 1'b0;
    apply_cfg();
    do_reset();
    bus.sdram_init_done = 1'b0;
    hits = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (bus.sdram_wr_req !== 1'b0 || bus.sdram_rd_req !== 1'b0) hits++;
    end
    check("init_block", hits, 0);
    wr_len = 0; rd_len = 64; rd_min = 0; rd_max = 1024; rd_lvl = 0; rd_en_m = 1'b1;
    apply_cfg();
    bus.sdram_init_done = 1'b1;
    next_burst(64, -1);
    rd_min = 32; apply_cfg();
    next_burst(64, -1);
    next_burst(64, 3);
    next_burst(64, -1);

    // Short burst sets sticky error
    rd_len = 0; rd_en_m = 1'b0; rd_min = 0;
    wr_min = 0; wr_max = 1024; wr_len = 8; wr_lvl = 1000;
    apply_cfg();
    do_reset();
    next_burst(7, -1);
    next_burst(8, -1);
    wr_len = 0; apply_cfg();
    repeat (5) @(negedge clk);
    #1;
    check("err_sticky", bus.burst_err, 1);
    do_reset();
    @(negedge clk); #1;
    check("err_cleared", bus.burst_err, 0);

    // Reset on the 3rd ack cycle of a write burst
    wr_min = 100; wr_max = 2000; wr_len = 16;
    apply_cfg();
    do_reset();
    wait_req(gw, at);
    check("mr_chan", gw, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sdram_wr_ack = 1'b1;
      bus.wr_fifo_q = 16'($urandom);
      if (i == 2) rst_n = 1'b0;
    end
    @(negedge clk); #1;
    check("mr_wr_req", bus.sdram_wr_req, 0);
    check("mr_rd_req", bus.sdram_rd_req, 0);
    check("mr_pop", bus.wr_fifo_rdreq, 0);
    check("mr_push", bus.rd_fifo_wrreq, 0);
    check("mr_wr_addr", bus.sdram_wr_addr, 0);
    check("mr_wr_burst", bus.sdram_wr_burst, 0);
    bus.sdram_wr_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr_a = 0; exp_rd_a = 0;
    wr_pend_m = 1'b1; rd_pend_m = 1'b1;
    last_wr_m = 1'b0; err_m = 1'b0; last_end = -100;
    next_burst(16, -1);

    // Randomized regions with both channels competing
    for (int t = 0; t < 4; t++) begin
      wr_len = $urandom_range(1, 40);
      rd_len = $urandom_range(1, 40);
      if (t == 3) begin
        wr_min = 2097151 - $urandom_range(60, 200);
        rd_min = 2097151 - $urandom_range(60, 200);
        wr_max = 2097151;
        rd_max = 2097151;
      end else begin
        wr_min = $urandom_range(0, 5000);
        rd_min = $urandom_range(0, 5000);
        wr_max = wr_min + $urandom_range(wr_len, 6 * wr_len);
        rd_max = rd_min + $urandom_range(rd_len, 6 * rd_len);
      end
      wr_lvl = $urandom_range(wr_len, 2047);
      rd_lvl = $urandom_range(0, 1024 - rd_len);
      rd_en_m = 1'b1;
      apply_cfg();
      do_reset();
      repeat (8) next_burst(1, -1) ;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_burst_master.md
# sdram_burst_master

Client-side burst requester for the SDRAM controller's user ports. It moves data from an external show-ahead write FIFO into SDRAM, and from SDRAM into an external read FIFO. It does this through whole-burst requests on the controller's write and read request/acknowledge handshakes. Write and read addresses circulate between programmable bounds, and simultaneous demand is round-robin arbitrated. The block sits between the user FIFOs and the controller's `sdram_wr_*`/`sdram_rd_*` ports.

## Interface
- `RD_FIFO_DEPTH`, 1024 — depth in words of the external read FIFO; used for the space check.
- `clk`  in  1  controller clock, 100 MHz.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `sdram_init_done`  in  1  no request is issued while this is 0.
- `wr_min_addr`, `wr_max_addr`  in  21 each  write region; bounds are inclusive start and exclusive end.
- `rd_min_addr`, `rd_max_addr`  in  21 each  read region; same rules as the write region.
- `wr_len`, `rd_len`  in  10 each  burst length in words; a value of 0 disables that channel.
- `wr_load`, `rd_load`  in  1 each  pulse that rewinds the channel address to its min.
- `rd_en`  in  1  enables read bursts.
- `wr_fifo_level`  in  11  words available in the write FIFO.
- `wr_fifo_q`  in  16  head word of the write FIFO (show-ahead).
- `wr_fifo_rdreq`  out  1  pop strobe for the write FIFO.
- `rd_fifo_level`  in  11  words currently held in the read FIFO.
- `rd_fifo_wrreq`  out  1  push strobe for the read FIFO.
- `rd_fifo_data`  out  16  data word pushed to the read FIFO.
- `sdram_wr_req`  out  1  write request to the controller.
- `sdram_wr_ack`  in  1  write acknowledge from the controller.
- `sdram_wr_addr`  out  21  write burst start address.
- `sdram_wr_burst`  out  10  write burst length.
- `sdram_din`  out  16  write data to the controller.
- `sdram_rd_req`  out  1  read request to the controller.
- `sdram_rd_ack`  in  1  read acknowledge from the controller.
- `sdram_rd_addr`  out  21  read burst start address.
- `sdram_rd_burst`  out  10  read burst length.
- `sdram_dout`  in  16  read data from the controller.
- `burst_err`  out  1  sticky; a burst completed with a word count different from its programmed length.

## Operation
- FSM states: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA.
- Write eligibility: `wr_en_ok` = `wr_len != 0` && `wr_fifo_level >= wr_len`.
- Read eligibility: `rd_en_ok` = `rd_en` && `rd_len != 0` && `rd_fifo_level + rd_len <= RD_FIFO_DEPTH`.
  - The sum is evaluated at 12 bits.
- IDLE, with `sdram_init_done` = 1:
  - If exactly one channel is eligible, go to that channel's REQ state.
  - If both are eligible, serve the channel that was not served last. The `last_wr` flag resets to 0, so write wins the first tie.
- Entering a REQ state latches the channel's current address and length into `sdram_*_addr`/`sdram_*_burst`. These stay stable until the state returns to IDLE.
- In a REQ state, `sdram_*_req` = 1.
- REQ → DATA: on the first cycle the ack is sampled 1. The req register clears in that same edge.
- In WR_DATA:
  - `sdram_din` = `wr_fifo_q` (combinational).
  - `wr_fifo_rdreq` = `sdram_wr_ack` (combinational). One word is consumed per ack-high cycle.
- In RD_DATA, each ack-high cycle registers `rd_fifo_data` ← `sdram_dout` and `rd_fifo_wrreq` ← 1.
- A word counter increments on every ack-high cycle.
- Burst end is the ack falling edge (ack = 0 after ack = 1 in the previous cycle). At burst end:
  - Set `burst_err` if the count ≠ latched length.
  - Advance the address as below.
  - Toggle `last_wr`.
  - Go to IDLE.
- Address advance: `next` = `addr + len`.
  - If `next + len > max_addr`, or `next >= max_addr`, reload `min_addr`; otherwise use `next`.
  - Compare at 22 bits; no silent wrap past 2^21.
- `wr_load`/`rd_load`:
  - Seen in IDLE: rewinds the address immediately.
  - Seen during that channel's REQ/DATA: recorded as pending, applied at burst end, and overriding the advance.
- Input lengths/bounds are sampled only at REQ entry. Changes mid-burst take effect on the next burst.

## Timing
- Reset values: all strobes/reqs 0; `sdram_*_addr` and `sdram_*_burst` 0; `rd_fifo_data` 0; `burst_err` 0; both channel addresses = 0; FSM in IDLE.
  - The first burst starts at `min_addr`, because reset arms a pending load on both channels.
- `sdram_*_req` rises 1 cycle after eligibility is seen in IDLE, and falls 1 cycle after ack is first sampled high.
- Write data path: zero-latency from ack to pop.
- Read data path: 1-cycle latency from ack/dout to `rd_fifo_wrreq`/data.
- Minimum burst-to-burst gap: 2 cycles (end edge → IDLE → REQ).
- `sdram_init_done` falling in IDLE blocks new requests. An in-flight burst completes normally.
- Reset asserted mid-burst: all outputs return to reset values at the next edge, and the FIFOs are not touched further. Counts already popped are lost; that is accepted.
- `sdram_wr_req` and `sdram_rd_req` are never high together.

## Test plan
- Write wrap:
  - Stimulus: `wr_min_addr` = 0, `wr_max_addr` = 1024, `wr_len` = 256, level held ≥ 256, controller model acks 256 cycles.
  - Required: `sdram_wr_addr` = 0, 256, 512, 768, 0; exactly 256 `wr_fifo_rdreq` pulses per burst; `burst_err` = 0.
- Tie arbitration:
  - Stimulus: both channels eligible continuously, `wr_len` = `rd_len` = 8.
  - Required: request order W, R, W, R; requests never overlap; gap ≥ 2 cycles.
- Read backpressure:
  - Stimulus: `RD_FIFO_DEPTH` = 1024, `rd_len` = 64, `rd_fifo_level` = 961.
  - Required: no `sdram_rd_req`. Then `rd_fifo_level` = 960 → req rises next cycle.
  - Required: pushed data equals the `sdram_dout` sequence, delayed 1 cycle.
- Load and init:
  - Stimulus: `sdram_init_done` = 0 with eligible demand → no req. `rd_load` pulsed mid-read-burst at `rd_addr` = 128, `rd_min_addr` = 32.
  - Required: next `sdram_rd_addr` = 32.
- Short burst:
  - Stimulus: model acks 7 cycles for `wr_len` = 8.
  - Required: `burst_err` = 1 and stays set until `rst_n` = 0.
- Reset mid-burst:
  - Stimulus: `rst_n` = 0 on the 3rd ack cycle.
  - Required: next edge has all reqs/strobes 0 and FSM in IDLE; after release, first `sdram_wr_addr` = `wr_min_addr`.
